fp_accum_ctrl: RTL and testbench

FP_ACCUM_CTRL -- requirements
Module: fp_accum_ctrl

---
 rtl/fp_accum_ctrl.sv | 157 +++++++++++++++
 tb/tb_fp_accum_ctrl.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_accum_ctrl.sv
// fp_accum_ctrl: buffers IEEE-754 single operands in a small FIFO and drives an
// external multi-cycle FP adder, one element at a time, to accumulate each
// packet (closed by in_last) into a single sum with its element count.
module fp_accum_ctrl #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_op,
  input  logic        in_last,
  output logic        add_start,
  output logic        add_op,
  output logic [31:0] add_A,
  output logic [31:0] add_B,
  input  logic        add_ready,
  input  logic [31:0] add_Y,
  output logic [31:0] sum,
  output logic        sum_valid,
  output logic [15:0] count,
  output logic        busy,
  output logic        nan_flag,
  output logic        err
);

  localparam int DATA_W = 32;
  localparam int AW     = $clog2(DEPTH);
  localparam int TW     = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  // Saturating element counter increment.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Exponent all ones with a non-zero mantissa.
  function automatic logic is_nan(input logic [DATA_W-1:0] v);
    return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
  endfunction

  state_t              state;
  logic [DATA_W+1:0]   mem [DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [AW:0]         occ;
  logic [DATA_W+1:0]   head;
  logic                push;
  logic                pop;
  logic                flush;
  logic [DATA_W-1:0]   acc;
  logic [15:0]         count_int;
  logic                elem_last;
  logic [TW-1:0]       tmr;

  assign in_ready = (occ != (AW+1)'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = (state == IDLE) && (occ != '0);
  assign flush    = (state == WAIT) && !add_ready && (tmr == TW'(TIMEOUT - 2));
  assign head     = mem[rd_ptr];
  assign busy     = (state != IDLE);

  // FIFO storage: {op, last, data}; contents need no reset, pointers guard them.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_op, in_last, in_data};
  end

  // FIFO pointers and occupancy; a timeout discards everything queued.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // Control FSM; adder operands are loaded on the way into ISSUE so that
  // add_start and its operands appear together and hold until the result.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      count_int <= '0;
      elem_last <= 1'b0;
      tmr       <= '0;
      add_start <= 1'b0;
      add_op    <= 1'b0;
      add_A     <= '0;
      add_B     <= '0;
      sum       <= '0;
      sum_valid <= 1'b0;
      count     <= '0;
      nan_flag  <= 1'b0;
      err       <= 1'b0;
    end else begin
      add_start <= 1'b0;
      sum_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (occ != '0) begin
            add_A     <= acc;
            add_B     <= head[DATA_W-1:0];
            elem_last <= head[DATA_W];
            add_op    <= head[DATA_W+1];
            add_start <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          tmr   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (add_ready) begin
            acc       <= add_Y;
            count_int <= sat_inc(count_int);
            if (is_nan(add_Y)) nan_flag <= 1'b1;
            if (elem_last) begin
              sum       <= add_Y;
              count     <= sat_inc(count_int);
              sum_valid <= 1'b1;
              state     <= DONE;
            end else begin
              state <= IDLE;
            end
          end else if (tmr == TW'(TIMEOUT - 2)) begin
            err       <= 1'b1;
            acc       <= '0;
            count_int <= '0;
            state     <= IDLE;
          end else begin
            tmr <= tmr + 1'b1;
          end
        end
        DONE: begin
          acc       <= '0;
          count_int <= '0;
          nan_flag  <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_accum_ctrl.sv
// Testbench for fp_accum_ctrl: a 5-cycle behavioural FP adder drives the DUT,
// and a packet-level reference model predicts each sum, count and NaN flag.
module tb_fp_accum_ctrl;

  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        in_op = 1'b0;
  logic        in_last = 1'b0;
  logic        add_start;
  logic        add_op;
  logic [31:0] add_A;
  logic [31:0] add_B;
  logic        add_ready;
  logic [31:0] add_Y;
  logic [31:0] sum;
  logic        sum_valid;
  logic [15:0] count;
  logic        busy;
  logic        nan_flag;
  logic        err;

  logic        mdl_ready = 1'b0;
  logic [31:0] mdl_Y = '0;
  logic        inj_ready = 1'b0;
  logic [31:0] inj_Y = '0;

  assign add_ready = mdl_ready | inj_ready;
  assign add_Y     = inj_ready ? inj_Y : mdl_Y;

  always #5 clk = ~clk;

  fp_accum_ctrl #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_op(in_op), .in_last(in_last),
    .add_start(add_start), .add_op(add_op), .add_A(add_A), .add_B(add_B),
    .add_ready(add_ready), .add_Y(add_Y),
    .sum(sum), .sum_valid(sum_valid), .count(count), .busy(busy),
    .nan_flag(nan_flag), .err(err)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- float helpers ----------------
  function automatic bit is_nan(input logic [31:0] b);
    return (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
  endfunction

  function automatic real sp2r(input logic [31:0] b);
    int  e;
    real m;
    e = int'(b[30:23]);
    if (e == 0) return 0.0;
    m = 1.0 + real'(b[22:0]) / 8388608.0;
    while (e > 127) begin m = m * 2.0; e--; end
    while (e < 127) begin m = m / 2.0; e++; end
    return b[31] ? -m : m;
  endfunction

  function automatic logic [31:0] r2sp(input real r);
    logic        s;
    real         a;
    int          e;
    logic [22:0] f;
    if (r == 0.0) return 32'h0;
    s = (r < 0.0);
    a = s ? -r : r;
    e = 127;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0)  begin a = a * 2.0; e--; end
    f = 23'($rtoi((a - 1.0) * 8388608.0 + 0.5));
    return {s, 8'(e), f};
  endfunction

  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b, input logic op);
    if (is_nan(a)) return a;
    if (is_nan(b)) return b;
    return r2sp(op ? sp2r(a) - sp2r(b) : sp2r(a) + sp2r(b));
  endfunction

  // ---------------- behavioural adder ----------------
  int          lat = 5;
  bit          hang = 1'b0;
  int          bcnt = 0;
  logic [31:0] res = '0;

  always @(posedge clk) begin
    mdl_ready <= 1'b0;
    if (bcnt > 0) begin
      bcnt <= bcnt - 1;
      if (bcnt == 1) begin
        mdl_ready <= 1'b1;
        mdl_Y     <= res;
      end
    end
    if (add_start && !hang) begin
      bcnt <= lat - 1;
      res  <= fadd(add_A, add_B, add_op);
    end
  end

  // ---------------- monitors ----------------
  typedef struct packed {
    logic [31:0] s;
    logic [15:0] c;
    logic        n;
  } res_t;

  res_t obs_q[$];
  res_t exp_q[$];
  int   cyc = 0;
  int   n_start = 0;
  int   start_cyc = 0;
  int   pulse_err = 0;
  logic prev_sv = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (sum_valid) obs_q.push_back('{s: sum, c: count, n: nan_flag});
    if (sum_valid && prev_sv) pulse_err++;
    prev_sv = sum_valid;
    if (add_start) begin
      n_start++;
      start_cyc = cyc;
    end
  end

  // ---------------- packet reference model ----------------
  real         racc = 0.0;
  int          rcnt = 0;
  bit          rnan = 1'b0;
  logic [31:0] rnan_val = '0;

  task automatic ref_clear();
    racc = 0.0; rcnt = 0; rnan = 1'b0; rnan_val = '0;
  endtask

  task automatic ref_add(input bit op, input bit last, input logic [31:0] d);
    res_t e;
    if (is_nan(d)) begin
      if (!rnan) rnan_val = d;
      rnan = 1'b1;
    end else begin
      racc = op ? racc - sp2r(d) : racc + sp2r(d);
    end
    rcnt++;
    if (last) begin
      e.s = rnan ? rnan_val : r2sp(racc);
      e.c = 16'(rcnt);
      e.n = rnan;
      exp_q.push_back(e);
      ref_clear();
    end
  endtask

  // ---------------- stimulus helpers (called at a negedge) ----------------
  task automatic push(input bit op, input bit last, input logic [31:0] d, output int waited);
    waited   = 0;
    in_valid = 1'b1;
    in_op    = op;
    in_last  = last;
    in_data  = d;
    while (!in_ready && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check_val("push_accept_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0;
    ref_add(op, last, d);
  endtask

  task automatic wait_results(input int n, input int budget);
    int k = 0;
    while (obs_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check_val("result_count", 32'(obs_q.size()), 32'(n));
  endtask

  task automatic wait_start(input int s0, input int budget);
    int k = 0;
    while (n_start == s0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    check_val("add_start_seen", 32'(n_start > s0), 32'd1);
  endtask

  task automatic take(output res_t o);
    o = '0;
    if (obs_q.size() != 0) o = obs_q.pop_front();
    if (exp_q.size() != 0) void'(exp_q.pop_front());
  endtask

  task automatic compare_front(input string tag);
    res_t o, e;
    if (obs_q.size() == 0 || exp_q.size() == 0) begin
      check_val({tag, "_queue"}, 32'(obs_q.size() != 0 && exp_q.size() != 0), 32'd1);
      return;
    end
    o = obs_q.pop_front();
    e = exp_q.pop_front();
    check_val({tag, "_sum"}, o.s, e.s);
    check_val({tag, "_count"}, 32'(o.c), 32'(e.c));
    check_val({tag, "_nan"}, 32'(o.n), 32'(e.n));
  endtask

  task automatic check_reset_vals(input string pfx);
    check_val({pfx, "_in_ready"}, 32'(in_ready), 32'd1);
    check_val({pfx, "_add_start"}, 32'(add_start), 32'd0);
    check_val({pfx, "_add_op"}, 32'(add_op), 32'd0);
    check_val({pfx, "_add_A"}, add_A, 32'd0);
    check_val({pfx, "_add_B"}, add_B, 32'd0);
    check_val({pfx, "_sum"}, sum, 32'd0);
    check_val({pfx, "_sum_valid"}, 32'(sum_valid), 32'd0);
    check_val({pfx, "_count"}, 32'(count), 32'd0);
    check_val({pfx, "_busy"}, 32'(busy), 32'd0);
    check_val({pfx, "_nan_flag"}, 32'(nan_flag), 32'd0);
    check_val({pfx, "_err"}, 32'(err), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    res_t o;
    int   w;
    int   s0;
    int   k;
    int   total;

    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b0;
    @(negedge clk);

    // three-element packet: 1.0 + 2.0 + 0.5
    push(1'b0, 1'b0, 32'h3F800000, w);
    push(1'b0, 1'b0, 32'h40000000, w);
    push(1'b0, 1'b1, 32'h3F000000, w);
    wait_results(1, 200);
    take(o);
    check_val("p3_sum", o.s, 32'h40600000);
    check_val("p3_count", 32'(o.c), 32'd3);
    check_val("p3_nan", 32'(o.n), 32'd0);

    // subtraction from a fresh accumulator
    push(1'b1, 1'b1, 32'h3F800000, w);
    wait_results(1, 200);
    take(o);
    check_val("sub_sum", o.s, 32'hBF800000);
    check_val("sub_count", 32'(o.c), 32'd1);

    // slow adder: first element sits in the adder, the next 8 fill the FIFO
    lat = 40;
    for (int i = 0; i < 9; i++) push(1'b0, 1'b0, r2sp(real'(i + 1) / 2.0), w);
    check_val("full_in_ready", 32'(in_ready), 32'd0);
    push(1'b1, 1'b1, 32'h40400000, w);
    check_val("full_held_off", 32'(w > 10), 32'd1);
    lat = 5;
    wait_results(1, 3000);
    compare_front("stall");

    // NaN propagates and flags the packet, then clears for the next one
    push(1'b0, 1'b0, 32'h7FC00000, w);
    push(1'b0, 1'b1, 32'h3F800000, w);
    wait_results(1, 200);
    take(o);
    check_val("nan_sum", o.s, 32'h7FC00000);
    check_val("nan_count", 32'(o.c), 32'd2);
    check_val("nan_flag_at_sum", 32'(o.n), 32'd1);
    push(1'b0, 1'b1, 32'h40000000, w);
    k = 0;
    while (!busy && k < 50) begin @(negedge clk); k++; end
    check_val("nan_cleared_next", 32'(nan_flag), 32'd0);
    wait_results(1, 200);
    take(o);
    check_val("after_nan_sum", o.s, 32'h40000000);
    check_val("after_nan_flag", 32'(o.n), 32'd0);

    // randomized packets against the reference model
    for (int p = 0; p < 12; p++) begin
      int len;
      len = int'($urandom_range(1, 6));
      lat = int'($urandom_range(2, 9));
      for (int i = 0; i < len; i++) begin
        logic [31:0] v;
        int          kv;
        kv = int'($urandom_range(0, 64)) - 32;
        v  = ($urandom_range(0, 19) == 0) ? 32'h7FC00000 : r2sp(real'(kv) / 4.0);
        push(1'($urandom_range(0, 1)), (i == len - 1), v, w);
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end
    total = exp_q.size();
    wait_results(total, 3000);
    for (int p = 0; p < total; p++) compare_front("rand");

    // adder never answers: timeout after TIMEOUT cycles, FIFO flushed
    lat = 5;
    hang = 1'b1;
    s0 = n_start;
    push(1'b0, 1'b0, 32'h3F800000, w);
    push(1'b0, 1'b0, 32'h40000000, w);
    push(1'b0, 1'b0, 32'h40400000, w);
    push(1'b0, 1'b1, 32'h40800000, w);
    wait_start(s0, 50);
    k = 0;
    while (cyc < start_cyc + TIMEOUT - 1 && k < 200) begin @(negedge clk); k++; end
    check_val("to_err_before", 32'(err), 32'd0);
    @(negedge clk);
    check_val("to_err_at", 32'(err), 32'd1);
    @(negedge clk);
    check_val("to_busy_after", 32'(busy), 32'd0);
    check_val("to_in_ready_after", 32'(in_ready), 32'd1);
    repeat (3) @(negedge clk);
    check_val("to_flushed_busy", 32'(busy), 32'd0);
    check_val("to_no_sum", 32'(obs_q.size()), 32'd0);
    hang = 1'b0;
    ref_clear();
    exp_q.delete();

    // reset clears the sticky error
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check_val("reset_clears_err", 32'(err), 32'd0);

    // reset while waiting on the adder, then a late add_ready
    s0 = n_start;
    push(1'b0, 1'b1, 32'h3F800000, w);
    wait_start(s0, 50);
    @(negedge clk);
    check_val("rw_in_wait_busy", 32'(busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    inj_Y = 32'h40400000;
    inj_ready = 1'b1;
    @(negedge clk);
    inj_ready = 1'b0;
    repeat (6) @(negedge clk);
    check_val("rw_no_sum", 32'(obs_q.size()), 32'd0);
    check_reset_vals("rw");
    ref_clear();
    exp_q.delete();
    push(1'b0, 1'b1, 32'h40000000, w);
    wait_results(1, 200);
    take(o);
    check_val("rw_acc_zero_sum", o.s, 32'h40000000);
    check_val("rw_count", 32'(o.c), 32'd1);

    check_val("sum_valid_single_pulse", 32'(pulse_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
